// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage sizes and register index types.
package rename_pkg;
  localparam int NUM_AREGS_DEF = 32;
  localparam int NUM_PREGS_DEF = 64;
  localparam int RENAME_WIDTH_DEF = 2;
  localparam int COMMIT_WIDTH_DEF = 2;
  localparam int FL_DEPTH = NUM_PREGS_DEF - NUM_AREGS_DEF;
  localparam int PREG_W = $clog2(NUM_PREGS_DEF);
  localparam int AREG_W = $clog2(NUM_AREGS_DEF);
  localparam int FL_CW = $clog2(FL_DEPTH + 1);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: allocate/return bundle between rename, commit and the free list.
interface free_list_if import rename_pkg::*; #(
  parameter int PW = PREG_W,
  parameter int RW = RENAME_WIDTH_DEF,
  parameter int CMW = COMMIT_WIDTH_DEF,
  parameter int CW = FL_CW
);
  logic [RW-1:0] alloc_req;
  logic alloc_ready;
  logic [PW*RW-1:0] alloc_preg;
  logic [CMW-1:0] free_valid;
  logic [PW*CMW-1:0] free_preg;
  logic [CW-1:0] free_count;
  logic overflow_err;
  modport master(output alloc_req, free_valid, free_preg,
                 input alloc_ready, alloc_preg, free_count, overflow_err);
  modport slave(input alloc_req, free_valid, free_preg,
                output alloc_ready, alloc_preg, free_count, overflow_err);
endinterface

// File: rtl/slot_prefix_count.sv
// slot_prefix_count: per-slot count of set bits below each slot, plus total popcount.
module slot_prefix_count #(
  parameter int N = 2,
  localparam int W = $clog2(N + 1)
)(
  input  logic [N-1:0]   i_vec,
  output logic [W*N-1:0] o_prefix,
  output logic [W-1:0]   o_total
);
  logic [W-1:0] w_acc;
  always_comb begin
    o_prefix = '0;
    w_acc = '0;
    for (int k = 0; k < N; k++) begin
      o_prefix[k*W +: W] = w_acc;
      w_acc = w_acc + W'(i_vec[k]);
    end
    o_total = w_acc;
  end
endmodule

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical registers with multi-slot allocate and return.
module free_list import rename_pkg::*; #(
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int RENAME_WIDTH = RENAME_WIDTH_DEF,
  parameter int COMMIT_WIDTH = 2
)(
  input logic clk,
  input logic rst,
  free_list_if.slave bus
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCW = $clog2(RENAME_WIDTH + 1);
  localparam int FCW = $clog2(COMMIT_WIDTH + 1);
  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic r_err;
  logic [RCW*RENAME_WIDTH-1:0] w_apfx;
  logic [RCW-1:0] w_nalloc;
  logic [FCW*COMMIT_WIDTH-1:0] w_fpfx;
  logic [FCW-1:0] w_nfree;
  logic w_fire, w_ovf;
  int w_next;
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int off);
    return AW'((int'(base) + off) % DEPTH);
  endfunction
  slot_prefix_count #(.N(RENAME_WIDTH)) u_alloc_cnt (
    .i_vec(bus.alloc_req), .o_prefix(w_apfx), .o_total(w_nalloc));
  slot_prefix_count #(.N(COMMIT_WIDTH)) u_free_cnt (
    .i_vec(bus.free_valid), .o_prefix(w_fpfx), .o_total(w_nfree));
  assign bus.alloc_ready = r_count >= CW'(RENAME_WIDTH);
  assign bus.free_count = r_count;
  assign bus.overflow_err = r_err;
  assign w_fire = bus.alloc_ready && w_nalloc != '0;
  assign w_next = int'(r_count) - (w_fire ? int'(w_nalloc) : 0) + int'(w_nfree);
  assign w_ovf = w_next > DEPTH;
  for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_slot
    assign bus.alloc_preg[k*PW +: PW] = r_mem[wrap(r_head, int'(w_apfx[k*RCW +: RCW]))];
  end
  // An overflowing return is dropped whole; the allocate half still proceeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= PW'(NUM_AREGS + i);
      r_head <= '0;
      r_tail <= '0;
      r_count <= CW'(DEPTH);
      r_err <= 1'b0;
    end else begin
      if (w_fire) r_head <= wrap(r_head, int'(w_nalloc));
      if (!w_ovf) begin
        for (int k = 0; k < COMMIT_WIDTH; k++)
          if (bus.free_valid[k])
            r_mem[wrap(r_tail, int'(w_fpfx[k*FCW +: FCW]))] <= bus.free_preg[k*PW +: PW];
        r_tail <= wrap(r_tail, int'(w_nfree));
      end
      r_count <= CW'(w_ovf ? w_next - int'(w_nfree) : w_next);
      r_err <= r_err | w_ovf;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: randomized and directed checks of free_list against a queue model.
module tb_free_list;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  free_list_if #(.PW(6), .RW(2), .CMW(2), .CW(6)) bus();
  free_list #(.NUM_AREGS(32), .NUM_PREGS(64), .RENAME_WIDTH(2), .COMMIT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int q[$];
  int out[$];
  bit m_err;

  task automatic set(input logic [1:0] a, input logic [1:0] v, input int p0, input int p1);
    bus.alloc_req = a;
    bus.free_valid = v;
    bus.free_preg = {6'(p1), 6'(p0)};
    #1;
  endtask

  task automatic tick();
    int nf;
    @(posedge clk);
    if (rst) begin
      q.delete();
      out.delete();
      for (int i = 0; i < 32; i++) q.push_back(32 + i);
      m_err = 0;
    end else begin
      if (q.size() >= 2)
        for (int k = 0; k < 2; k++) if (bus.alloc_req[k]) out.push_back(q.pop_front());
      nf = int'(bus.free_valid[0]) + int'(bus.free_valid[1]);
      if (q.size() + nf > 32) m_err = 1;
      else for (int k = 0; k < 2; k++) if (bus.free_valid[k]) q.push_back(int'(bus.free_preg[k*6 +: 6]));
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    set(2'($urandom), 2'($urandom), int'($urandom % 64), int'($urandom % 64));
    tick();
    rst = 0;
    set(2'b00, 2'b00, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    set(2'b11, 2'b00, 0, 0);
    checks++; if (bus.free_count !== 6'd32) begin errors++; $display("FAIL reset_count got %0d want 32", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.alloc_ready); end
    checks++; if (bus.alloc_preg !== {6'd33, 6'd32}) begin errors++; $display("FAIL reset_preg got %h want %h", bus.alloc_preg, {6'd33, 6'd32}); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.overflow_err); end
    set(2'b00, 2'b00, 0, 0);
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set(2'b11, 2'b00, 0, 0);
      checks++;
      if (bus.alloc_preg !== {6'(33 + 2*i), 6'(32 + 2*i)}) begin
        errors++; $display("FAIL drain_pair%0d got %h want %0d,%0d", i, bus.alloc_preg, 33 + 2*i, 32 + 2*i);
      end
      tick();
    end
    checks++; if (bus.free_count !== 6'd0) begin errors++; $display("FAIL drain_count got %0d want 0", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %b want 0", bus.alloc_ready); end
    tick();
    checks++; if (bus.free_count !== 6'd0) begin errors++; $display("FAIL stall_count got %0d want 0", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", bus.alloc_ready); end
  endtask

  task automatic test_partial();
    do_reset();
    set(2'b10, 2'b00, 0, 0);
    checks++; if (bus.alloc_preg[11:6] !== 6'd32) begin errors++; $display("FAIL partial_slot1 got %0d want 32", bus.alloc_preg[11:6]); end
    tick();
    set(2'b01, 2'b00, 0, 0);
    checks++; if (bus.free_count !== 6'd31) begin errors++; $display("FAIL partial_count got %0d want 31", bus.free_count); end
    checks++; if (bus.alloc_preg[5:0] !== 6'd33) begin errors++; $display("FAIL partial_slot0 got %0d want 33", bus.alloc_preg[5:0]); end
    set(2'b00, 2'b00, 0, 0);
  endtask

  task automatic test_wrap();
    int p0, p1;
    do_reset();
    set(2'b11, 2'b00, 0, 0);
    repeat (16) tick();
    set(2'b00, 2'b11, 5, 9);
    tick();
    set(2'b11, 2'b00, 0, 0);
    checks++; if (bus.free_count !== 6'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", bus.free_count); end
    checks++; if (bus.alloc_preg !== {6'd9, 6'd5}) begin errors++; $display("FAIL wrap_first got %h want %h", bus.alloc_preg, {6'd9, 6'd5}); end
    for (int c = 0; c < 48; c++) begin
      p0 = out.size() > 0 ? out.pop_front() : 0;
      p1 = out.size() > 0 ? out.pop_front() : 0;
      set(2'b11, 2'b11, p0, p1);
      checks++;
      if (q.size() >= 2 && bus.alloc_preg !== {6'(q[1]), 6'(q[0])}) begin
        errors++; $display("FAIL wrap_order%0d got %h want %0d,%0d", c, bus.alloc_preg, q[1], q[0]);
      end
      tick();
    end
  endtask

  task automatic test_simul();
    do_reset();
    set(2'b11, 2'b00, 0, 0);
    repeat (15) tick();
    set(2'b11, 2'b01, 7, 0);
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b want 1", bus.alloc_ready); end
    tick();
    set(2'b01, 2'b00, 0, 0);
    checks++; if (bus.free_count !== 6'd1) begin errors++; $display("FAIL simul_count got %0d want 1", bus.free_count); end
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL simul_stall got %b want 0", bus.alloc_ready); end
    checks++; if (bus.alloc_preg[5:0] !== 6'd7) begin errors++; $display("FAIL simul_slot0 got %0d want 7", bus.alloc_preg[5:0]); end
    set(2'b00, 2'b00, 0, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    set(2'b00, 2'b01, 3, 0);
    tick();
    set(2'b00, 2'b00, 0, 0);
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", bus.overflow_err); end
    checks++; if (bus.free_count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d want 32", bus.free_count); end
    set(2'b11, 2'b00, 0, 0);
    repeat (3) tick();
    checks++; if (bus.free_count !== 6'd26) begin errors++; $display("FAIL ovf_drain got %0d want 26", bus.free_count); end
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow_err); end
    do_reset();
    set(2'b11, 2'b00, 0, 0);
    checks++; if (bus.free_count !== 6'd32) begin errors++; $display("FAIL midrst_count got %0d want 32", bus.free_count); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", bus.overflow_err); end
    checks++; if (bus.alloc_preg !== {6'd33, 6'd32}) begin errors++; $display("FAIL midrst_preg got %h want %h", bus.alloc_preg, {6'd33, 6'd32}); end
    set(2'b00, 2'b00, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] a, v;
    int p[2];
    int j, idx;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 60) == 0;
      a = 2'($urandom);
      v = 2'b00;
      for (int k = 0; k < 2; k++) begin
        p[k] = 0;
        if (out.size() > 0 && $urandom % 2 == 1) begin
          j = int'($urandom % out.size());
          p[k] = out[j];
          out.delete(j);
          v[k] = 1'b1;
        end else if ($urandom % 25 == 0) begin
          p[k] = int'($urandom % 64);
          v[k] = 1'b1;
        end
      end
      set(a, v, p[0], p[1]);
      checks++; if (bus.free_count !== 6'(q.size())) begin errors++; $display("FAIL rnd_count%0d got %0d want %0d", c, bus.free_count, q.size()); end
      checks++; if (bus.alloc_ready !== (q.size() >= 2)) begin errors++; $display("FAIL rnd_ready%0d got %b want %b", c, bus.alloc_ready, q.size() >= 2); end
      checks++; if (bus.overflow_err !== m_err) begin errors++; $display("FAIL rnd_err%0d got %b want %b", c, bus.overflow_err, m_err); end
      for (int k = 0; k < 2; k++) begin
        idx = (k == 1) ? int'(a[0]) : 0;
        if (idx < q.size()) begin
          checks++;
          if (bus.alloc_preg[k*6 +: 6] !== 6'(q[idx])) begin
            errors++; $display("FAIL rnd_slot%0d_%0d got %0d want %0d", k, c, bus.alloc_preg[k*6 +: 6], q[idx]);
          end
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    set(2'b00, 2'b00, 0, 0);
    test_reset();
    test_drain();
    test_partial();
    test_wrap();
    test_simul();
    test_overflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
